ecg_suffix_decoder: RTL and testbench
=====================================

ECG_SUFFIX_DECODER -- requirements
Module: ecg_suffix_decoder

Interface
REQ-001 Parameter J, default 10: signed sample width, legal range 4..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 blk_start  input  1  sync pulse; restarts decoding at ECG 0 of a new block.
REQ-005 in_bit  input  1  serial bitstream bit, MSB-first per field.
REQ-006 in_valid  input  1  in_bit valid; bit consumed when in_valid && in_ready.
REQ-007 in_ready  output  1  decoder can accept a bit this cycle.
REQ-008 out_valid  output  1  decoded ECG group available.
REQ-009 out_ready  input  1  sink accepts group; transfer when out_valid && out_ready.
REQ-010 out_sample_1..out_sample_4  output  J each  decoded signed samples.
REQ-011 out_ecgidx  output  2  ECG index of the presented group.
REQ-012 out_bits_req  output  4  decoded bits-required of the presented group.
REQ-013 err  output  1  sticky prefix-range error flag.

Function
REQ-014 Group format: 4-bit prefix bits_req (B), then suffix for samples 1..4 in order.
REQ-015 ECG 0..2, SM form: each sample is B magnitude bits, then 1 sign bit (1 = negative) only if magnitude != 0.
REQ-016 ECG 3, 2C form: each sample is B bits, sign-extended from bit B-1 to J bits.
REQ-017 B == 0: no suffix; all four samples decode to 0.
REQ-018 States: PREFIX (4 bits) -> MAG (B bits/sample) -> SIGN (SM only, nonzero mag) -> next sample or OUT; PREFIX -> OUT when B == 0; OUT -> PREFIX on output transfer.
REQ-019 in_ready = 1 in PREFIX/MAG/SIGN, 0 in OUT (and in ERR, see REQ-030).
REQ-020 Exactly one bit consumed per handshake cycle; no bit consumed when in_valid = 0.
REQ-021 out_valid rises the cycle after the last bit of the group is consumed; 1-cycle latency.
REQ-022 Outputs held stable while out_valid && !out_ready.
REQ-023 ecgidx counter: increments mod 4 on each output transfer; 3 -> 0 wraps to next block.
REQ-024 blk_start: ecgidx <= 0, state <= PREFIX, partial group discarded, out_valid <= 0, err <= 0.
REQ-025 blk_start has priority over a same-cycle bit handshake; that bit is discarded.
REQ-026 blk_start concurrent with output transfer: transfer completes, then ecgidx forced 0.
REQ-027 Samples assembled in J-bit registers; SM negative result = two's complement of magnitude.

Reset
REQ-028 rst_n low: state PREFIX, ecgidx 0, in_ready 0 during reset then 1, out_valid 0, out_sample_* 0, out_ecgidx 0, out_bits_req 0, err 0.
REQ-029 Reset mid-group discards all partial data; first bit after reset is prefix MSB of ECG 0.

Configuration
REQ-030 Macro ECG_DEC_RANGE_CHECK_EN defined: prefix B > J sets err, enters ERR state (in_ready 0, out_valid 0) until blk_start or reset.
REQ-031 Macro undefined: err tied 0; B > J decoded normally, samples truncated to J LSBs.

Verification
REQ-032 ECG0, bits 0011 101 1 000 011 0 111 0 -> out_sample 1..4 = -5, 0, 3, 7; out_bits_req 3; out_ecgidx 0.
REQ-033 ECG3 (after 3 groups of prefix 0000), bits 0011 101 011 000 111 -> -3, 3, 0, -1; next group out_ecgidx 0.
REQ-034 Prefix 0000 -> out_valid 1 cycle after 4th bit, all samples 0, no suffix consumed.
REQ-035 Hold out_ready 0 for 5 cycles with in_valid 1 -> in_ready 0, outputs stable, no bits lost.
REQ-036 blk_start mid-MAG of ECG1 with in_valid 1 -> bit discarded, next group decodes as ECG0.
REQ-037 With ECG_DEC_RANGE_CHECK_EN, J=10, prefix 1100 -> err 1, in_ready 0 until blk_start clears it.

Source files
------------

// File: rtl/ecg_suffix_decoder_if.sv
// Stream interface for the ECG suffix decoder: serial bit input side and decoded group output side.
// master = bitstream source / group sink, slave = decoder.
interface ecg_suffix_decoder_if #(
  parameter int unsigned J = 10
) ();
  logic         blk_start;
  logic         in_bit;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [J-1:0] out_sample_1;
  logic [J-1:0] out_sample_2;
  logic [J-1:0] out_sample_3;
  logic [J-1:0] out_sample_4;
  logic [1:0]   out_ecgidx;
  logic [3:0]   out_bits_req;
  logic         err;

  modport master (
    output blk_start, in_bit, in_valid, out_ready,
    input  in_ready, out_valid, out_sample_1, out_sample_2, out_sample_3, out_sample_4,
    input  out_ecgidx, out_bits_req, err
  );

  modport slave (
    input  blk_start, in_bit, in_valid, out_ready,
    output in_ready, out_valid, out_sample_1, out_sample_2, out_sample_3, out_sample_4,
    output out_ecgidx, out_bits_req, err
  );
endinterface

// File: rtl/ecg_suffix_decoder.sv
// Serial ECG group decoder: 4-bit bits-required prefix, then four SM (ECG 0..2) or 2C (ECG 3) samples.
// Optional prefix range check enabled by defining ECG_DEC_RANGE_CHECK_EN.
module ecg_suffix_decoder #(
  parameter int unsigned J = 10
) (
  input logic                clk,
  input logic                rst_n,
  ecg_suffix_decoder_if.slave bus
);

  typedef enum logic [2:0] {StPrefix, StMag, StSign, StOut, StErr} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         b_q, b_d;
  logic [1:0]         smp_idx_q, smp_idx_d;
  logic [1:0]         ecgidx_q, ecgidx_d;
  logic [J-1:0]       acc_q, acc_d;
  logic               nz_q, nz_d;
  logic [2:0][J-1:0]  smp_q, smp_d;
  logic [3:0][J-1:0]  out_smp_q, out_smp_d;
  logic [1:0]         out_idx_q, out_idx_d;
  logic [3:0]         out_breq_q, out_breq_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic               fire;
  logic [3:0]         b_new;
  logic [J-1:0]       acc_shift;
  logic               nz_shift;
  logic [J-1:0]       sext_val;
  logic [J-1:0]       neg_val;
  logic               sbit;
  logic               done_smp;
  logic [J-1:0]       smp_val;

  assign fire      = bus.in_valid && in_ready_q;
  assign b_new     = {b_q[2:0], bus.in_bit};
  // Shifting into a J-bit register keeps only the J LSBs when B exceeds J.
  assign acc_shift = {acc_q[J-2:0], bus.in_bit};
  assign nz_shift  = nz_q | bus.in_bit;
  assign neg_val   = '0 - acc_q;

`ifdef ECG_DEC_RANGE_CHECK_EN
  logic err_q, err_d;
  logic b_over;
  assign b_over  = {28'd0, b_new} > J;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  always_comb begin
    sbit     = 1'b0;
    sext_val = acc_shift;
    for (int unsigned i = 0; i < J; i++) begin
      if (i == {28'd0, b_q} - 32'd1) sbit = acc_shift[i];
    end
    for (int unsigned i = 0; i < J; i++) begin
      if (i >= {28'd0, b_q}) sext_val[i] = sbit;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    b_d         = b_q;
    smp_idx_d   = smp_idx_q;
    ecgidx_d    = ecgidx_q;
    acc_d       = acc_q;
    nz_d        = nz_q;
    smp_d       = smp_q;
    out_smp_d   = out_smp_q;
    out_idx_d   = out_idx_q;
    out_breq_d  = out_breq_q;
    out_valid_d = out_valid_q;
    done_smp    = 1'b0;
    smp_val     = '0;
`ifdef ECG_DEC_RANGE_CHECK_EN
    err_d       = err_q;
`endif

    unique case (state_q)
      StPrefix: begin
        if (fire) begin
          b_d   = b_new;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd3) begin
            cnt_d     = '0;
            smp_idx_d = '0;
            acc_d     = '0;
            nz_d      = 1'b0;
            if (b_new == 4'd0) begin
              state_d     = StOut;
              out_smp_d   = '0;
              out_idx_d   = ecgidx_q;
              out_breq_d  = 4'd0;
              out_valid_d = 1'b1;
            end else begin
              state_d = StMag;
            end
`ifdef ECG_DEC_RANGE_CHECK_EN
            if (b_over) begin
              state_d = StErr;
              err_d   = 1'b1;
            end
`endif
          end
        end
      end
      StMag: begin
        if (fire) begin
          acc_d = acc_shift;
          nz_d  = nz_shift;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == b_q - 4'd1) begin
            if (ecgidx_q == 2'd3) begin
              done_smp = 1'b1;
              smp_val  = sext_val;
            end else if (nz_shift) begin
              state_d = StSign;
            end else begin
              done_smp = 1'b1;
            end
          end
        end
      end
      StSign: begin
        if (fire) begin
          done_smp = 1'b1;
          smp_val  = bus.in_bit ? neg_val : acc_q;
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          ecgidx_d    = ecgidx_q + 2'd1;
          state_d     = StPrefix;
          cnt_d       = '0;
        end
      end
      StErr: ;
      default: state_d = StPrefix;
    endcase

    if (done_smp) begin
      cnt_d = '0;
      acc_d = '0;
      nz_d  = 1'b0;
      if (smp_idx_q == 2'd3) begin
        out_smp_d   = {smp_val, smp_q[2], smp_q[1], smp_q[0]};
        out_idx_d   = ecgidx_q;
        out_breq_d  = b_q;
        out_valid_d = 1'b1;
        state_d     = StOut;
      end else begin
        smp_d[smp_idx_q] = smp_val;
        smp_idx_d        = smp_idx_q + 2'd1;
        state_d          = StMag;
      end
    end

    // Block sync wins over any same-cycle bit; a same-cycle output transfer still completes.
    if (bus.blk_start) begin
      state_d     = StPrefix;
      cnt_d       = '0;
      smp_idx_d   = '0;
      acc_d       = '0;
      nz_d        = 1'b0;
      ecgidx_d    = '0;
      out_valid_d = 1'b0;
`ifdef ECG_DEC_RANGE_CHECK_EN
      err_d       = 1'b0;
`endif
    end

    in_ready_d = (state_d == StPrefix) || (state_d == StMag) || (state_d == StSign);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StPrefix;
      cnt_q       <= '0;
      b_q         <= '0;
      smp_idx_q   <= '0;
      ecgidx_q    <= '0;
      acc_q       <= '0;
      nz_q        <= 1'b0;
      smp_q       <= '0;
      out_smp_q   <= '0;
      out_idx_q   <= '0;
      out_breq_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
`ifdef ECG_DEC_RANGE_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      b_q         <= b_d;
      smp_idx_q   <= smp_idx_d;
      ecgidx_q    <= ecgidx_d;
      acc_q       <= acc_d;
      nz_q        <= nz_d;
      smp_q       <= smp_d;
      out_smp_q   <= out_smp_d;
      out_idx_q   <= out_idx_d;
      out_breq_q  <= out_breq_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef ECG_DEC_RANGE_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sample_1 = out_smp_q[0];
  assign bus.out_sample_2 = out_smp_q[1];
  assign bus.out_sample_3 = out_smp_q[2];
  assign bus.out_sample_4 = out_smp_q[3];
  assign bus.out_ecgidx   = out_idx_q;
  assign bus.out_bits_req = out_breq_q;

endmodule

// File: tb/tb_ecg_suffix_decoder.sv
// Scoreboard bench for ecg_suffix_decoder (J = 10): directed groups, expected groups queued at issue.
module tb_ecg_suffix_decoder;

  localparam int unsigned J = 10;

  logic clk;
  logic rst_n;

  ecg_suffix_decoder_if #(.J(J)) bus ();

  ecg_suffix_decoder #(.J(J)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int s1;
    int s2;
    int s3;
    int s4;
    int idx;
    int breq;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_grp(input int s1, input int s2, input int s3, input int s4,
                            input int idx, input int breq);
    exp_t e;
    e.s1 = s1; e.s2 = s2; e.s3 = s3; e.s4 = s4; e.idx = idx; e.breq = breq;
    sb.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) chk("in_ready_timeout", int'(bus.in_ready), 1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "0") send_bit(1'b0);
      else if (s[i] == "1") send_bit(1'b1);
    end
  endtask

  // Drops in_valid on the negedge after the last bit and checks the 1-cycle output latency.
  task automatic end_group(input string name);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk(name, int'(bus.out_valid), 1);
  endtask

  task automatic set_out_ready(input logic v);
    @(posedge clk);
    #1 bus.out_ready = v;
  endtask

  // Monitor: pops one expected group per output transfer.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_group", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sample_1", int'($signed(bus.out_sample_1)), e.s1);
        chk("sample_2", int'($signed(bus.out_sample_2)), e.s2);
        chk("sample_3", int'($signed(bus.out_sample_3)), e.s3);
        chk("sample_4", int'($signed(bus.out_sample_4)), e.s4);
        chk("ecgidx", int'(bus.out_ecgidx), e.idx);
        chk("bits_req", int'(bus.out_bits_req), e.breq);
      end
    end
  end

  initial begin
    int waited;
    rst_n         = 1'b0;
    bus.blk_start = 1'b0;
    bus.in_bit    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_sample_1", int'(bus.out_sample_1), 0);
    chk("rst_sample_4", int'(bus.out_sample_4), 0);
    chk("rst_ecgidx", int'(bus.out_ecgidx), 0);
    chk("rst_bits_req", int'(bus.out_bits_req), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(bus.in_ready), 1);

    // ECG0, SM form, B = 3
    expect_grp(-5, 0, 3, 7, 0, 3);
    send_str("0011 101 1 000 011 0 111 0");
    end_group("ecg0_latency");

    // ECG1, B = 0: no suffix
    expect_grp(0, 0, 0, 0, 1, 0);
    send_str("0000");
    end_group("zero_prefix_latency");

    // ECG2, B = 2, held under backpressure with bits offered
    set_out_ready(1'b0);
    expect_grp(-2, 1, 0, -3, 2, 2);
    send_str("0010 10 1 01 0 00 11 1");
    end_group("ecg2_latency");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'b1;
      chk("hold_in_ready", int'(bus.in_ready), 0);
      chk("hold_out_valid", int'(bus.out_valid), 1);
      chk("hold_sample_1", int'($signed(bus.out_sample_1)), -2);
      chk("hold_sample_4", int'($signed(bus.out_sample_4)), -3);
      chk("hold_ecgidx", int'(bus.out_ecgidx), 2);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    set_out_ready(1'b1);

    // ECG3, 2C form, B = 3
    expect_grp(-3, 3, 0, -1, 3, 3);
    send_str("0011 101 011 000 111");
    end_group("ecg3_latency");

    // Wrap to ECG0 of the next block
    expect_grp(0, 0, 0, 0, 0, 0);
    send_str("0000");
    end_group("wrap_latency");

    // ECG1 partial group, then blk_start mid-MAG with a bit offered
    send_str("0011 1");
    @(negedge clk);
    bus.blk_start = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_bit    = 1'b1;
    @(negedge clk);
    bus.blk_start = 1'b0;
    bus.in_valid  = 1'b0;
    chk("blk_out_valid", int'(bus.out_valid), 0);
    chk("blk_in_ready", int'(bus.in_ready), 1);
    expect_grp(-1, 1, 0, 0, 0, 1);
    send_str("0001 1 1 1 0 0 0");
    end_group("blk_restart_latency");

`ifdef ECG_DEC_RANGE_CHECK_EN
    send_str("1100");
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("range_err", int'(bus.err), 1);
    chk("range_in_ready", int'(bus.in_ready), 0);
    chk("range_out_valid", int'(bus.out_valid), 0);
    repeat (3) @(negedge clk);
    chk("range_err_sticky", int'(bus.err), 1);
    bus.blk_start = 1'b1;
    @(negedge clk);
    bus.blk_start = 1'b0;
    chk("range_err_clear", int'(bus.err), 0);
    chk("range_in_ready_back", int'(bus.in_ready), 1);
    expect_grp(0, 0, 0, 0, 0, 0);
    send_str("0000");
    end_group("range_recover_latency");
`else
    // ECG1, B = 12 > J: magnitudes keep the 10 LSBs; a nonzero but truncated-to-0 magnitude
    // still carries its sign bit.
    expect_grp(-5, 0, 0, 3, 1, 12);
    send_str("1100 000000000101 1 100000000000 1 000000000000 000000000011 0");
    end_group("trunc_latency");
    chk("trunc_err", int'(bus.err), 0);
`endif

    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("sb_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
